// File: rtl/bitwise_pkg.sv
// Shared definitions for the bitwise result FIFO: entry layout and helpers.
package bitwise_pkg;

  localparam int ENTRY_W        = 10;
  // Bit offsets of each field inside a stored entry / out_data.
  localparam int OR_BITWISE_LSB = 7;
  localparam int OR_LOGICAL_BIT = 6;
  localparam int NOT_LSB        = 0;

  // Packed so the struct maps onto out_data MSB-first.
  typedef struct packed {
    logic [2:0] or_bitwise;
    logic       or_logical;
    logic [5:0] inv;
  } result_t;

  // The logical OR must agree with "any bit of the bitwise OR is set".
  function automatic logic is_consistent(input result_t r);
    return r.or_logical == (r.or_bitwise != 3'b000);
  endfunction

endpackage

// File: rtl/bitwise_fifo_mem.sv
// Entry storage: one write port, one combinational read port.
module bitwise_fifo_mem
  import bitwise_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  result_t       wr_data,
  input  logic [AW-1:0] rd_addr,
  output result_t       rd_data
);

  result_t mem [DEPTH];

  // Write the accepted entry; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read is asynchronous so the head entry falls through to the output.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bitwise_result_fifo.sv
// FIFO of operator-stage results with a saturating logical-true counter
// and a sticky consistency error flag.
module bitwise_result_fifo
  import bitwise_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_or_bitwise,
  input  logic                     in_or_logical,
  input  logic [5:0]               in_not,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ENTRY_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               true_cnt,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [7:0]    true_cnt_reg, true_cnt_next;
  logic          err_reg, err_next;

  result_t in_entry;
  result_t head_entry;
  logic    push;
  logic    pop;

  assign in_entry = '{or_bitwise: in_or_bitwise, or_logical: in_or_logical, inv: in_not};

  // Handshake flags depend only on the registered count, never on out_ready.
  assign in_ready  = (count_reg < FULL_COUNT);
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  bitwise_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr_reg),
    .wr_data (in_entry),
    .rd_addr (rd_ptr_reg),
    .rd_data (head_entry)
  );

  assign out_data = head_entry;
  assign count    = count_reg;
  assign true_cnt = true_cnt_reg;
  assign err      = err_reg;

  // Next-state: pointers wrap naturally (power-of-two depth), count nets push/pop.
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    true_cnt_next = true_cnt_reg;
    err_next      = err_reg;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    if (push && in_or_logical && (true_cnt_reg != 8'hFF)) begin
      true_cnt_next = true_cnt_reg + 1'b1;
    end
    // Inconsistent results are still stored, only flagged.
    if (push && !is_consistent(in_entry)) begin
      err_next = 1'b1;
    end
  end

  // State register; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      true_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      true_cnt_reg <= true_cnt_next;
      err_reg      <= err_next;
    end
  end

endmodule

// File: tb/tb_bitwise_result_fifo.sv
// Bench for bitwise_result_fifo: directed table, corner sequences, random run
// against a queue-based reference model.
module tb_bitwise_result_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_or_bitwise;
  logic          in_or_logical;
  logic [5:0]    in_not;
  logic          out_valid;
  logic          out_ready;
  logic [9:0]    out_data;
  logic [CW-1:0] count;
  logic [7:0]    true_cnt;
  logic          err;

  always #5 clk = ~clk;

  bitwise_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_or_bitwise (in_or_bitwise),
    .in_or_logical (in_or_logical),
    .in_not        (in_not),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .count         (count),
    .true_cnt      (true_cnt),
    .err           (err)
  );

  int tests = 0;
  int fails = 0;
  bit verbose = 1'b1;

  // Reference model: a plain queue of entries plus the two side counters.
  logic [9:0] mq[$];
  int         m_tc;
  bit         m_err;

  typedef struct {
    bit         v;
    bit         rdy;
    logic [2:0] bw;
    bit         lg;
    logic [5:0] nt;
    int         e_count;
    bit         e_ovalid;
    bit         e_iready;
    logic [9:0] e_data;
    int         e_tc;
    bit         e_err;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input bit v, input bit rdy, input logic [2:0] bw, input bit lg,
                       input logic [5:0] nt);
    in_valid      = v;
    out_ready     = rdy;
    in_or_bitwise = bw;
    in_or_logical = lg;
    in_not        = nt;
  endtask

  // Apply the rules to the inputs currently presented, as of the coming edge.
  task automatic model_step();
    bit         acc;
    bit         pp;
    logic [9:0] e;
    if (reset) begin
      mq.delete();
      m_tc  = 0;
      m_err = 1'b0;
      if (verbose) $display("[TB] reset");
    end else begin
      acc = in_valid && (mq.size() < DEPTH);
      pp  = (mq.size() != 0) && out_ready;
      e   = {in_or_bitwise, in_or_logical, in_not};
      if (pp) begin
        if (verbose) $display("[TB] pop  %b", mq[0]);
        void'(mq.pop_front());
      end
      if (acc) begin
        mq.push_back(e);
        if (in_or_logical && m_tc < 255) m_tc++;
        if (in_or_logical != (in_or_bitwise != 3'b000)) m_err = 1'b1;
        if (verbose) $display("[TB] push %b", e);
      end
    end
  endtask

  task automatic check_model();
    chk("count", 32'(count), 32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("true_cnt", 32'(true_cnt), 32'(m_tc));
    chk("err", 32'(err), 32'(m_err));
    if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
  endtask

  task automatic cycle(input bit do_check);
    model_step();
    @(posedge clk);
    #1;
    if (do_check) check_model();
  endtask

  task automatic push_consistent(input bit rdy);
    logic [2:0] bw;
    bw = 3'($urandom_range(0, 7));
    drive(1'b1, rdy, bw, bw != 3'b000, 6'($urandom));
  endtask

  initial begin
    // Directed table: fill past full with out_ready=0, then drain.
    tbl[0] = '{1, 0, 3'b101, 1, 6'b101010, 1, 1, 1, 10'b1011101010, 1, 0};
    tbl[1] = '{1, 0, 3'b010, 1, 6'b000111, 2, 1, 1, 10'b1011101010, 2, 0};
    tbl[2] = '{1, 0, 3'b000, 0, 6'b111111, 3, 1, 1, 10'b1011101010, 2, 0};
    tbl[3] = '{1, 0, 3'b111, 1, 6'b000000, 4, 1, 0, 10'b1011101010, 3, 0};
    tbl[4] = '{1, 0, 3'b001, 1, 6'b010101, 4, 1, 0, 10'b1011101010, 3, 0};
    tbl[5] = '{0, 1, 3'b000, 0, 6'b000000, 3, 1, 1, 10'b0101000111, 3, 0};
    tbl[6] = '{0, 1, 3'b000, 0, 6'b000000, 2, 1, 1, 10'b0000111111, 3, 0};
    tbl[7] = '{0, 1, 3'b000, 0, 6'b000000, 1, 1, 1, 10'b1111000000, 3, 0};
    tbl[8] = '{0, 1, 3'b000, 0, 6'b000000, 0, 0, 1, 10'b0000000000, 3, 0};

    m_tc  = 0;
    m_err = 1'b0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 1'b0, 6'b0);
    #1;
    cycle(1'b0);
    cycle(1'b1);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].rdy, tbl[i].bw, tbl[i].lg, tbl[i].nt);
      cycle(1'b0);
      $display("[TB] row %0d count=%0d out_valid=%0b out_data=%b", i, count, out_valid, out_data);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_count));
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ovalid));
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_iready));
      chk($sformatf("tbl%0d_true_cnt", i), 32'(true_cnt), 32'(tbl[i].e_tc));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].e_err));
      if (tbl[i].e_ovalid) chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_data));
    end

    // Full with in_valid and out_ready: only the pop happens.
    for (int i = 0; i < DEPTH; i++) begin
      push_consistent(1'b0);
      cycle(1'b1);
    end
    push_consistent(1'b1);
    cycle(1'b1);
    chk("full_push_pop_count", 32'(count), 32'd3);
    drive(1'b0, 1'b1, 3'b000, 1'b0, 6'b0);
    cycle(1'b1);
    // Steady push+pop at count=2 wraps both pointers.
    for (int i = 0; i < 10; i++) begin
      push_consistent(1'b1);
      cycle(1'b1);
      chk("steady_count", 32'(count), 32'd2);
    end
    drive(1'b0, 1'b1, 3'b000, 1'b0, 6'b0);
    cycle(1'b1);
    cycle(1'b1);

    // Inconsistent entry sets err, entry is stored, err is sticky until reset.
    drive(1'b1, 1'b0, 3'b000, 1'b1, 6'h3F);
    cycle(1'b1);
    chk("err_set", 32'(err), 32'd1);
    chk("err_entry_stored", 32'(out_data), 32'(10'b0001111111));
    push_consistent(1'b0);
    cycle(1'b1);
    chk("err_sticky", 32'(err), 32'd1);
    reset = 1'b1;
    cycle(1'b1);
    reset = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);

    // 260 logical-true pushes while draining: counter saturates.
    verbose = 1'b0;
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 1'b1, 3'($urandom_range(1, 7)), 1'b1, 6'($urandom));
      cycle(1'b1);
    end
    chk("true_cnt_saturated", 32'(true_cnt), 32'd255);
    verbose = 1'b1;

    // Reset in the middle of traffic with count=3.
    reset = 1'b1;
    cycle(1'b1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_consistent(1'b0);
      cycle(1'b1);
    end
    chk("pre_reset_count", 32'(count), 32'd3);
    push_consistent(1'b1);
    reset = 1'b1;
    cycle(1'b0);
    reset = 1'b0;
    chk("midreset_count", 32'(count), 32'd0);
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    chk("midreset_true_cnt", 32'(true_cnt), 32'd0);

    // Random traffic, occasional inconsistent data and resets.
    verbose = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic [2:0] bw;
      bit         lg;
      bw = 3'($urandom_range(0, 7));
      lg = ($urandom_range(0, 15) == 0) ? ~(bw != 3'b000) : (bw != 3'b000);
      drive(1'($urandom), 1'($urandom), bw, lg, 6'($urandom));
      reset = ($urandom_range(0, 63) == 0);
      cycle(1'b1);
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
